mul_hilo_ctrl: RTL and testbench
================================

MUL_HILO_CTRL -- requirements
Module: mul_hilo_ctrl

Interface
REQ-001 SHALL have parameter MUL_WAIT, default 2: cycles allowed for the combinational multiplier array to settle (legal 1..15).
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: request one signed 32x32 multiply of a by b.
REQ-005 SHALL have ports a and b, input, 32 each: signed multiplicand and multiplier, sampled only on an accepted start.
REQ-006 SHALL have ports mul_x and mul_y, output, 32 each: registered operands driven to the multiplier array's x and y inputs.
REQ-007 SHALL have port mul_p, input, 64: signed product returned by the multiplier array.
REQ-008 SHALL have port bus_in, input, 32: datapath bus for direct HI/LO loads.
REQ-009 SHALL have ports hi_in and lo_in, input, 1 each: load bus_in into HI or LO.
REQ-010 SHALL have ports hi_out and lo_out, output, 32 each: HI and LO register contents.
REQ-011 SHALL have ports busy and done, output, 1 each: operation in flight; one-cycle completion pulse.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, WAIT, CAPTURE.
REQ-013 In IDLE, start=1 SHALL be accepted at the clock edge: mul_x<=a, mul_y<=b, wait counter<=MUL_WAIT-1, next state WAIT.
REQ-014 In WAIT, the counter SHALL decrement each cycle; at counter 0 the next state SHALL be CAPTURE.
REQ-015 In CAPTURE, the edge SHALL load HI<=mul_p[63:32], LO<=mul_p[31:0], pulse done=1 for exactly the following cycle, and return to IDLE.
REQ-016 Latency SHALL be MUL_WAIT+1 cycles from the edge accepting start to the edge loading HI/LO; done SHALL be high in the cycle immediately after that edge.
REQ-017 busy SHALL be 1 in WAIT and CAPTURE and 0 in IDLE; done and busy SHALL never both be 1.
REQ-018 start asserted while busy=1 SHALL be ignored, with no queuing and no change to mul_x/mul_y.
REQ-019 start asserted in the same cycle done=1 (FSM in IDLE) SHALL be accepted, giving back-to-back operation.
REQ-020 mul_x and mul_y SHALL remain stable from acceptance until the next accepted start.
REQ-021 hi_in=1 SHALL load HI<=bus_in and lo_in=1 SHALL load LO<=bus_in at the edge; both may assert together.
REQ-022 If hi_in or lo_in coincides with the CAPTURE edge, the multiplier product SHALL win for both registers and the bus write SHALL be dropped.
REQ-023 hi_in/lo_in during IDLE or WAIT SHALL take effect and SHALL not disturb the FSM; a later CAPTURE overwrites them.
REQ-024 Product interpretation SHALL be two's-complement signed; no truncation or saturation.

Reset
REQ-025 clr=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, counter=0, mul_x=0, mul_y=0, HI=0, LO=0, busy=0, done=0.
REQ-026 clr asserted mid-operation SHALL abort the operation with no HI/LO update and no done pulse.
REQ-027 After clr deasserts, the first start SHALL be accepted at the first rising edge with clr=0.

Verification
REQ-028 Bench SHALL drive mul_p from a signed behavioural product of mul_x*mul_y, or from the real array, with a MUL_WAIT-cycle settling model.
REQ-029 Scenario 1: start with a=7, b=-3 (0xFFFFFFFD) -> after MUL_WAIT+1 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB, done high for one cycle.
REQ-030 Scenario 2: a=b=0x80000000 -> HI=0x40000000, LO=0x00000000; then a=0x7FFFFFFF, b=2 -> HI=0x00000000, LO=0xFFFFFFFE.
REQ-031 Scenario 3: second start pulsed while busy -> ignored; first result unchanged; only one done pulse.
REQ-032 Scenario 4: hi_in=1 with bus_in=0x12345678 on the CAPTURE edge of 5*6 -> HI=0, LO=30; hi_in in IDLE -> HI=0x12345678.
REQ-033 Scenario 5: clr pulsed in the middle of WAIT -> all outputs 0 asynchronously; no done pulse; next start completes normally.
REQ-034 Scenario 6: start held high continuously -> results every MUL_WAIT+2 cycles, each with exactly one done pulse.

Source files
------------

// File: rtl/mul_hilo_ctrl.sv
// HI/LO register controller for an external combinational signed 32x32 multiplier array.
// Holds operands stable while the array settles, then captures the 64-bit product into HI/LO.
module mul_hilo_ctrl #(
    parameter int unsigned MUL_WAIT = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [63:0] mul_p,
    input  logic [31:0] bus_in,
    input  logic        hi_in,
    input  logic        lo_in,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MUL_WAIT - 1);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] mul_x_r, mul_y_r, hi_r, lo_r;
    logic        busy_r, done_r;
    logic        accept_s, capture_s;

    // Next-state and counter logic for the settle/capture sequence
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    cnt_s    = WAIT_INIT;
                    state_s  = ST_WAIT;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_CAPTURE;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_CAPTURE: begin
                capture_s = 1'b1;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM state, counter and registered status flags
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= capture_s;
        end
    end

    // Operand registers: only an accepted start may change what the array sees
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mul_x_r <= 32'd0;
            mul_y_r <= 32'd0;
        end else if (accept_s) begin
            mul_x_r <= a;
            mul_y_r <= b;
        end else begin
            mul_x_r <= mul_x_r;
            mul_y_r <= mul_y_r;
        end
    end

    // HI/LO update: a product capture takes priority over any bus write
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (capture_s) begin
            hi_r <= mul_p[63:32];
            lo_r <= mul_p[31:0];
        end else begin
            hi_r <= hi_in ? bus_in : hi_r;
            lo_r <= lo_in ? bus_in : lo_r;
        end
    end

    assign mul_x  = mul_x_r;
    assign mul_y  = mul_y_r;
    assign hi_out = hi_r;
    assign lo_out = lo_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed self-checking bench for mul_hilo_ctrl with a behavioural multiplier array
// whose product is only valid after the operands have been stable for MUL_WAIT edges.
module tb_mul_hilo_ctrl;

    localparam int MUL_WAIT = 2;

    logic        clk = 1'b0;
    logic        clr, start, hi_in, lo_in;
    logic [31:0] a, b, bus_in;
    logic [31:0] mul_x, mul_y, hi_out, lo_out;
    logic [63:0] mul_p;
    logic        busy, done;

    int checks = 0;
    int failures = 0;

    mul_hilo_ctrl #(.MUL_WAIT(MUL_WAIT)) dut (
        .clk(clk), .clr(clr), .start(start), .a(a), .b(b),
        .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
        .bus_in(bus_in), .hi_in(hi_in), .lo_in(lo_in),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Multiplier array model: garbage until operands have been stable long enough
    logic signed [63:0] prod;
    logic [31:0] px = 32'd0, py = 32'd0;
    int settle = MUL_WAIT;

    assign prod = $signed({{32{mul_x[31]}}, mul_x}) * $signed({{32{mul_y[31]}}, mul_y});

    always @(posedge clk) begin
        if (mul_x != px || mul_y != py) begin
            px <= mul_x;
            py <= mul_y;
            settle <= 1;
        end else if (settle < MUL_WAIT) begin
            settle <= settle + 1;
        end
    end

    always_comb begin
        mul_p = 64'hBAD0_BAD0_BAD0_BAD0;
        if (mul_x == px && mul_y == py && settle >= MUL_WAIT) mul_p = prod;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] eh, input logic [31:0] el, input string tag);
        int n;
        a = av; b = bv; start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, "_x"}, mul_x, av);
        chk({tag, "_y"}, mul_y, bv);
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        while (!done && n < 20) begin
            chk({tag, "_excl"}, busy & done, 0);
            tick;
            n++;
        end
        chk({tag, "_lat"}, n, MUL_WAIT + 1);
        chk({tag, "_hi"}, hi_out, eh);
        chk({tag, "_lo"}, lo_out, el);
        chk({tag, "_idle"}, busy, 0);
        tick;
        chk({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse, prev;
        clr = 1'b1; start = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
        a = 32'd0; b = 32'd0; bus_in = 32'd0;
        #1;
        chk("rst_hi", hi_out, 0);
        chk("rst_lo", lo_out, 0);
        chk("rst_x", mul_x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick; tick;
        clr = 1'b0;

        // Scenario 1: 7 * -3
        run_mul(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "s1");

        // Scenario 2: extreme operands
        run_mul(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "s2a");
        run_mul(32'h7FFF_FFFF, 32'd2, 32'h0000_0000, 32'hFFFF_FFFE, "s2b");

        // Scenario 3: start while busy is ignored
        a = 32'd11; b = 32'd13; start = 1'b1;
        tick;
        a = 32'd100; b = 32'd100;
        tick;
        start = 1'b0;
        chk("s3_x_hold", mul_x, 32'd11);
        chk("s3_y_hold", mul_y, 32'd13);
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) npulse++;
            tick;
        end
        chk("s3_pulses", npulse, 1);
        chk("s3_hi", hi_out, 32'd0);
        chk("s3_lo", lo_out, 32'd143);

        // Scenario 4: bus write on the capture edge loses to the product
        a = 32'd5; b = 32'd6; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        hi_in = 1'b1; bus_in = 32'h1234_5678;
        tick;
        hi_in = 1'b0;
        chk("s4_done", done, 1);
        chk("s4_hi", hi_out, 32'd0);
        chk("s4_lo", lo_out, 32'd30);
        hi_in = 1'b1;
        tick;
        hi_in = 1'b0;
        chk("s4_hi_bus", hi_out, 32'h1234_5678);
        chk("s4_lo_keep", lo_out, 32'd30);
        hi_in = 1'b1; lo_in = 1'b1; bus_in = 32'hCAFE_F00D;
        tick;
        hi_in = 1'b0; lo_in = 1'b0;
        chk("s4_both_hi", hi_out, 32'hCAFE_F00D);
        chk("s4_both_lo", lo_out, 32'hCAFE_F00D);

        // Scenario 5: clear in the middle of WAIT
        a = 32'd9; b = 32'd9; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        #2 clr = 1'b1;
        #1;
        chk("s5_hi", hi_out, 0);
        chk("s5_lo", lo_out, 0);
        chk("s5_x", mul_x, 0);
        chk("s5_y", mul_y, 0);
        chk("s5_busy", busy, 0);
        chk("s5_done", done, 0);
        tick;
        #1 clr = 1'b0;
        run_mul(32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, "s5r");

        // Scenario 6: start held high gives one result every MUL_WAIT+2 cycles
        a = 32'd2; b = 32'd3; start = 1'b1;
        npulse = 0; prev = -1;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("s6_excl", busy & done, 0);
            if (done) begin
                if (prev >= 0) chk("s6_period", i - prev, MUL_WAIT + 2);
                chk("s6_lo", lo_out, 32'd6);
                prev = i;
                npulse++;
            end
        end
        start = 1'b0;
        chk("s6_pulses", npulse, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
